// File: rtl/axi_burst_sequencer.sv
// AXI4 master sequencer: runs one INCR burst (AR/R or AW/W/B) per command and reports completion.
// Optional watchdog abort enabled by defining AXI_SEQ_TIMEOUT_EN.
module axi_burst_sequencer #(
  parameter int unsigned ID_W        = 6,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ID_VAL      = 0,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              done,
  output logic [1:0]        done_resp,
  output logic              timeout,
  output logic              M_AXI_AWVALID,
  input  logic              M_AXI_AWREADY,
  output logic [ID_W-1:0]   M_AXI_AWID,
  output logic [ADDR_W-1:0] M_AXI_AWADDR,
  output logic [7:0]        M_AXI_AWLEN,
  output logic [2:0]        M_AXI_AWSIZE,
  output logic [1:0]        M_AXI_AWBURST,
  output logic              M_AXI_WVALID,
  input  logic              M_AXI_WREADY,
  output logic [DATA_W-1:0] M_AXI_WDATA,
  output logic [3:0]        M_AXI_WSTRB,
  output logic              M_AXI_WLAST,
  input  logic              M_AXI_BVALID,
  output logic              M_AXI_BREADY,
  input  logic [ID_W-1:0]   M_AXI_BID,
  input  logic [1:0]        M_AXI_BRESP,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  output logic [ID_W-1:0]   M_AXI_ARID,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic [7:0]        M_AXI_ARLEN,
  output logic [2:0]        M_AXI_ARSIZE,
  output logic [1:0]        M_AXI_ARBURST,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY,
  input  logic [ID_W-1:0]   M_AXI_RID,
  input  logic [DATA_W-1:0] M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RLAST
);

  localparam int unsigned SUM_W = ADDR_W + 11;
  localparam logic [ID_W-1:0]  ID_C       = ID_W'(ID_VAL);
  localparam logic [SUM_W-1:0] ADDR_SPAN  = SUM_W'(1) << ADDR_W;
  localparam logic [15:0]      WDOG_LIMIT = 16'(TIMEOUT_CYC - 1);
`ifdef AXI_SEQ_TIMEOUT_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_CHK, S_AR, S_R, S_AW, S_W, S_B, S_DONE
  } state_e;

  state_e            state_q, state_nxt;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [7:0]        beat_q;
  logic [1:0]        resp_q;
  logic              timeout_q;
  logic              cmd_ready_q;
  logic [15:0]       wdog_q;

  logic [SUM_W-1:0]  end_addr;
  logic              chk_bad;
  logic              any_hs;
  logic              busy;
  logic              wdog_hit;
  logic [1:0]        r_beat_resp;

  // Static address/control fields come straight from the latched command
  assign M_AXI_AWID    = ID_C;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWLEN   = len_q;
  assign M_AXI_AWSIZE  = 3'd2;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_ARID    = ID_C;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARLEN   = len_q;
  assign M_AXI_ARSIZE  = 3'd2;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_WDATA   = wr_data;
  assign M_AXI_WSTRB   = 4'hF;
  assign rd_data       = M_AXI_RDATA;
  assign cmd_ready     = cmd_ready_q;

  // End address computed wide enough that len=255 cannot wrap
  assign end_addr    = SUM_W'(addr_q) + ((SUM_W'(len_q) + SUM_W'(1)) << 2);
  assign chk_bad     = (addr_q[1:0] != 2'b00) || (end_addr > ADDR_SPAN);
  assign r_beat_resp = (M_AXI_RID != ID_C) ? 2'b10 : M_AXI_RRESP;

  always_comb begin
    state_nxt     = state_q;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_WLAST   = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    wr_ready      = 1'b0;
    rd_valid      = 1'b0;
    rd_last       = 1'b0;
    done          = 1'b0;
    done_resp     = 2'b00;
    timeout       = 1'b0;
    any_hs        = 1'b0;
    busy          = 1'b0;
    wdog_hit      = 1'b0;
    case (state_q)
      S_IDLE: if (cmd_valid && cmd_ready_q) state_nxt = S_CHK;
      S_CHK: begin
        if (chk_bad)      state_nxt = S_DONE;
        else if (write_q) state_nxt = S_AW;
        else              state_nxt = S_AR;
      end
      S_AR: begin
        busy          = 1'b1;
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) begin
          any_hs    = 1'b1;
          state_nxt = S_R;
        end
      end
      S_R: begin
        busy         = 1'b1;
        M_AXI_RREADY = rd_ready;
        rd_valid     = M_AXI_RVALID;
        rd_last      = M_AXI_RLAST;
        if (M_AXI_RVALID && rd_ready) begin
          any_hs = 1'b1;
          if (M_AXI_RLAST || (beat_q == len_q)) state_nxt = S_DONE;
        end
      end
      S_AW: begin
        busy          = 1'b1;
        M_AXI_AWVALID = 1'b1;
        if (M_AXI_AWREADY) begin
          any_hs    = 1'b1;
          state_nxt = S_W;
        end
      end
      S_W: begin
        busy         = 1'b1;
        M_AXI_WVALID = wr_valid;
        wr_ready     = M_AXI_WREADY;
        M_AXI_WLAST  = (beat_q == len_q);
        if (wr_valid && M_AXI_WREADY) begin
          any_hs = 1'b1;
          if (beat_q == len_q) state_nxt = S_B;
        end
      end
      S_B: begin
        busy         = 1'b1;
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) begin
          any_hs    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        done_resp = resp_q;
        timeout   = timeout_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Watchdog abort: the stalled channel is released when DONE is entered
    if (WDOG_EN && busy && !any_hs && (wdog_q == WDOG_LIMIT)) begin
      wdog_hit  = 1'b1;
      state_nxt = S_DONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_nxt;
  end

  // Command latch, beat counter, response accumulation and watchdog
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_q     <= 1'b0;
      addr_q      <= '0;
      len_q       <= 8'd0;
      beat_q      <= 8'd0;
      resp_q      <= 2'b00;
      timeout_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      wdog_q      <= 16'd0;
    end else begin
      cmd_ready_q <= (state_nxt == S_IDLE);
      case (state_q)
        S_IDLE: if (cmd_valid && cmd_ready_q) begin
          write_q <= cmd_write;
          addr_q  <= cmd_addr;
          len_q   <= cmd_len;
        end
        S_CHK: begin
          beat_q    <= 8'd0;
          resp_q    <= chk_bad ? 2'b11 : 2'b00;
          timeout_q <= 1'b0;
        end
        S_R: if (M_AXI_RVALID && rd_ready) begin
          beat_q <= beat_q + 8'd1;
          if (r_beat_resp > resp_q) resp_q <= r_beat_resp;
        end
        S_W: if (wr_valid && M_AXI_WREADY) beat_q <= beat_q + 8'd1;
        S_B: if (M_AXI_BVALID) resp_q <= (M_AXI_BID != ID_C) ? 2'b10 : M_AXI_BRESP;
        default: ;
      endcase
      if (wdog_hit) begin
        resp_q    <= 2'b11;
        timeout_q <= 1'b1;
      end
      if (busy && !any_hs) wdog_q <= wdog_q + 16'd1;
      else                 wdog_q <= 16'd0;
    end
  end

endmodule

// File: tb/tb_axi_burst_sequencer.sv
// Randomized bench for axi_burst_sequencer: AXI slave memory model, command-level reference model.
module tb_axi_burst_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_ready, cmd_write;
  logic [5:0]  cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic        done, timeout;
  logic [1:0]  done_resp;
  logic        M_AXI_AWVALID, M_AXI_AWREADY;
  logic [5:0]  M_AXI_AWID, M_AXI_AWADDR;
  logic [7:0]  M_AXI_AWLEN;
  logic [2:0]  M_AXI_AWSIZE;
  logic [1:0]  M_AXI_AWBURST;
  logic        M_AXI_WVALID, M_AXI_WREADY, M_AXI_WLAST;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_BVALID, M_AXI_BREADY;
  logic [5:0]  M_AXI_BID;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_ARVALID, M_AXI_ARREADY;
  logic [5:0]  M_AXI_ARID, M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic        M_AXI_RVALID, M_AXI_RREADY, M_AXI_RLAST;
  logic [5:0]  M_AXI_RID;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;

  axi_burst_sequencer dut (
    .clk(clk), .reset(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .done_resp(done_resp), .timeout(timeout),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_AWID(M_AXI_AWID),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWSIZE(M_AXI_AWSIZE),
    .M_AXI_AWBURST(M_AXI_AWBURST),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_WDATA(M_AXI_WDATA),
    .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_BID(M_AXI_BID),
    .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_ARID(M_AXI_ARID),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
    .M_AXI_ARBURST(M_AXI_ARBURST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY), .M_AXI_RID(M_AXI_RID),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave configuration and state
  int          stall = 0;
  bit          hold_aw = 1'b0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [5:0]  bid_cfg = 6'd0, rid_cfg = 6'd0;
  int          early_last = -1;
  logic [31:0] mem [16];
  logic [31:0] model_mem [16];
  int          aw_count = 0, ar_count = 0, w_beats = 0;
  logic [24:0] aw_rec, ar_rec;
  bit          in_wr, b_pend, r_active;
  int          w_word, w_len, w_beat, r_word, r_len, r_beat;

  bit          rd_gap = 1'b0, wr_gap = 1'b0;
  logic [31:0] wq[$];
  logic [31:0] rdq[$];
  logic        lastq[$];
  int          cyc = 0;
  int          cr_viol = 0;
  bit          in_cmd = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit go();
    return ($urandom_range(99) >= stall);
  endfunction

  // AXI slave backed by a 16-word memory; drives at negedge, observes handshakes 1 unit later
  initial begin
    {M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RLAST} = '0;
    M_AXI_BID = '0; M_AXI_BRESP = '0; M_AXI_RID = '0; M_AXI_RDATA = '0; M_AXI_RRESP = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_wr = 0; b_pend = 0; r_active = 0;
        {M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_ARREADY, M_AXI_RVALID} = '0;
        continue;
      end
      M_AXI_AWREADY = !hold_aw && go();
      M_AXI_WREADY  = go();
      M_AXI_BVALID  = b_pend;
      M_AXI_BRESP   = bresp_cfg;
      M_AXI_BID     = bid_cfg;
      M_AXI_ARREADY = go();
      M_AXI_RVALID  = r_active && go();
      M_AXI_RDATA   = mem[(r_word + r_beat) % 16];
      M_AXI_RLAST   = (r_beat == r_len) || (r_beat == early_last);
      M_AXI_RRESP   = rresp_cfg;
      M_AXI_RID     = rid_cfg;
      #1;
      if (M_AXI_WVALID && !in_wr) check("w_without_aw", 1, 0);
      if (M_AXI_WVALID && M_AXI_WREADY && in_wr) begin
        check("wlast", M_AXI_WLAST, w_beat == w_len);
        check("wstrb", M_AXI_WSTRB, 4'hF);
        mem[(w_word + w_beat) % 16] = M_AXI_WDATA;
        w_beats++;
        if (w_beat == w_len) begin in_wr = 0; b_pend = 1; end
        else w_beat++;
      end
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        aw_count++;
        aw_rec = {M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWID};
        in_wr = 1; w_word = int'(M_AXI_AWADDR) / 4; w_len = int'(M_AXI_AWLEN); w_beat = 0;
      end
      if (M_AXI_BVALID && M_AXI_BREADY) b_pend = 0;
      if (M_AXI_RVALID && M_AXI_RREADY) begin
        if (M_AXI_RLAST) r_active = 0;
        else r_beat++;
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        ar_count++;
        ar_rec = {M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARID};
        r_active = 1; r_word = int'(M_AXI_ARADDR) / 4; r_len = int'(M_AXI_ARLEN); r_beat = 0;
      end
    end
  end

  // Read-stream consumer
  initial begin
    rd_ready = 1'b0;
    forever begin
      @(negedge clk);
      rd_ready = rd_gap ? ($urandom_range(3) != 0) : 1'b1;
      #1;
      if (rd_valid && rd_ready) begin
        rdq.push_back(rd_data);
        lastq.push_back(rd_last);
      end
    end
  end

  // Write-stream producer
  initial begin
    wr_valid = 1'b0; wr_data = '0;
    forever begin
      @(negedge clk);
      if (wq.size() > 0) begin
        wr_valid = wr_gap ? ($urandom_range(3) != 0) : 1'b1;
        wr_data  = wq[0];
      end else wr_valid = 1'b0;
      #1;
      if (wr_valid && wr_ready) void'(wq.pop_front());
    end
  end

  // cmd_ready must stay low between accept and done
  initial forever begin
    @(negedge clk); #1;
    if (!rst_n) in_cmd = 0;
    else begin
      if (in_cmd && cmd_ready) cr_viol++;
      if (cmd_valid && cmd_ready) in_cmd = 1;
      if (done) in_cmd = 0;
    end
  end

  function automatic bit is_legal(input int addr, input int len);
    return (addr % 4 == 0) && (addr + (len + 1) * 4 <= 64);
  endfunction

  function automatic logic [1:0] exp_resp(input bit wr, input int addr, input int len);
    if (!is_legal(addr, len)) return 2'b11;
    if (wr) return (bid_cfg != 0) ? 2'b10 : bresp_cfg;
    if (rid_cfg != 0) return (rresp_cfg > 2'b10) ? rresp_cfg : 2'b10;
    return rresp_cfg;
  endfunction

  task automatic run_cmd(input bit wr, input logic [5:0] addr, input logic [7:0] len, input int budget,
                         output logic [1:0] resp, output logic to, output int lat);
    int n, t0;
    resp = 2'b00; to = 1'b0; lat = -1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    #1; n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (!cmd_ready) begin check("cmd_accept_wait", 0, 1); cmd_valid = 1'b0; return; end
    t0 = cyc;
    @(negedge clk); cmd_valid = 1'b0;
    #1; n = 0;
    while (!done && n < budget) begin @(negedge clk); #1; n++; end
    if (!done) begin check("done_wait", 0, 1); return; end
    resp = done_resp; to = timeout; lat = cyc - t0;
    @(negedge clk); #1;
    check("done_one_cycle", done, 0);
  endtask

  task automatic xfer(input bit wr, input int addr, input int len, input bit seq);
    logic [1:0]  er, resp;
    logic        to;
    int          lat, aw0, ar0, nb;
    bit          legal;
    logic [31:0] d[$];
    legal = is_legal(addr, len);
    er = exp_resp(wr, addr, len);
    if (wr && legal)
      for (int i = 0; i <= len; i++) d.push_back(seq ? 32'hA0 + 32'(i) : $urandom);
    wq = d;
    rdq.delete(); lastq.delete();
    aw0 = aw_count; ar0 = ar_count;
    run_cmd(wr, 6'(addr), 8'(len), 400, resp, to, lat);
    check("resp", resp, er);
    check("timeout_flag", to, 0);
    check("aw_count", aw_count - aw0, legal && wr);
    check("ar_count", ar_count - ar0, legal && !wr);
    if (!legal) check("reject_latency", lat, 2);
    if (legal && wr) begin
      check("wr_consumed", wq.size(), 0);
      for (int i = 0; i <= len; i++) model_mem[(addr / 4 + i) % 16] = d[i];
    end
    if (legal && !wr) begin
      nb = (early_last >= 0 && early_last < len) ? early_last + 1 : len + 1;
      check("rd_beats", rdq.size(), nb);
      for (int i = 0; i < nb && i < rdq.size(); i++) begin
        check("rd_data", rdq[i], model_mem[(addr / 4 + i) % 16]);
        check("rd_last", lastq[i], i == nb - 1);
      end
    end
    wq.delete();
  endtask

  initial begin
    int n, wb0, lat;
    logic [1:0] resp;
    logic to;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    for (int i = 0; i < 16; i++) begin mem[i] = $urandom; model_mem[i] = mem[i]; end

    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", {cmd_ready, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                            M_AXI_RREADY, rd_valid, wr_ready, done, done_resp, timeout}, 0);
    @(negedge clk); rst_n = 1'b1;

    // Directed bursts
    xfer(1, 'h10, 3, 1);
    check("t1_aw_fields", aw_rec, {6'h10, 8'd3, 3'd2, 2'b01, 6'd0});
    for (int i = 0; i < 4; i++) check("t1_mem", mem[4 + i], 32'hA0 + 32'(i));
    xfer(0, 'h10, 3, 0);
    check("t2_ar_fields", ar_rec, {6'h10, 8'd3, 3'd2, 2'b01, 6'd0});
    xfer(1, 'h02, 0, 0);
    xfer(0, 'h38, 2, 0);
    xfer(1, 'h38, 1, 0);
    xfer(0, 'h00, 15, 0);
    xfer(1, 'h00, 255, 0);

    // Response codes, ID mismatch and early RLAST
    bresp_cfg = 2'b10; xfer(1, 'h20, 2, 0); bresp_cfg = 2'b00;
    bid_cfg = 6'd5;    xfer(1, 'h20, 0, 0); bid_cfg = 6'd0;
    rresp_cfg = 2'b01; xfer(0, 'h20, 2, 0); rresp_cfg = 2'b00;
    rid_cfg = 6'd9;    xfer(0, 'h00, 1, 0); rid_cfg = 6'd0;
    early_last = 1;    xfer(0, 'h00, 5, 0); early_last = -1;

    // Randomized traffic with stalls and stream gaps
    stall = 30; rd_gap = 1; wr_gap = 1;
    for (int k = 0; k < 40; k++) begin
      int a, l;
      bresp_cfg = 2'($urandom_range(3));
      rresp_cfg = 2'($urandom_range(3));
      a = ($urandom_range(7) == 0) ? $urandom_range(63) : $urandom_range(15) * 4;
      l = ($urandom_range(9) == 0) ? $urandom_range(255) : $urandom_range(15);
      xfer($urandom_range(1) == 1, a, l, 0);
    end
    check("cmd_ready_low_while_busy", cr_viol, 0);
    stall = 0; rd_gap = 0; wr_gap = 0; bresp_cfg = 2'b00; rresp_cfg = 2'b00;

    // Reset during the second write beat
    wq = '{32'h11, 32'h22, 32'h33, 32'h44};
    wb0 = w_beats;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h00; cmd_len = 8'd3;
    #1; n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk); cmd_valid = 1'b0;
    #1; n = 0;
    while (w_beats < wb0 + 1 && n < 50) begin @(negedge clk); #1; n++; end
    check("t6_first_beat", w_beats - wb0, 1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("t6_reset_outputs", {cmd_ready, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                               M_AXI_RREADY, rd_valid, wr_ready, done, done_resp, timeout}, 0);
    wq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    xfer(1, 'h00, 3, 1);
    xfer(0, 'h00, 3, 0);

`ifdef AXI_SEQ_TIMEOUT_EN
    hold_aw = 1'b1;
    wq = '{32'h55};
    run_cmd(1, 6'h00, 8'd0, 2000, resp, to, lat);
    check("t7_resp", resp, 2'b11);
    check("t7_timeout", to, 1);
    check("t7_latency_window", (lat >= 1025 && lat <= 1027), 1);
    check("t7_awvalid_dropped", M_AXI_AWVALID, 0);
    hold_aw = 1'b0;
    wq.delete();
    xfer(1, 'h00, 0, 0);
`else
    resp = 2'b00; to = 1'b0; lat = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_time_limit: got %0d cycles expected completion", cyc);
    $fatal(1, "time limit");
  end

endmodule
